// File: rtl/jtopl_acc_pkg.sv
// Shared helpers for the operator-path accumulators:
// saturation limits, sign extension and add-with-overflow.
package jtopl_acc_pkg;

    typedef struct packed {
        logic [31:0] sum;
        logic        ovf;
    } add_res_t;

    function automatic logic [31:0] sat_max(input int w);
        logic [31:0] m;
        m = '1;
        return m >> (33 - w);
    endfunction

    function automatic logic [31:0] sat_min(input int w);
        return ~sat_max(w);
    endfunction

    function automatic logic [31:0] sext(input logic [31:0] x, input int w);
        logic signed [31:0] t;
        t = x << (32 - w);
        return t >>> (32 - w);
    endfunction

    // Overflow is judged at width w: operand signs agree, result sign differs
    function automatic add_res_t add_ovf(
        input logic [31:0] a,
        input logic [31:0] b,
        input int          w
    );
        add_res_t r;
        r.sum = a + b;
        r.ovf = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
        return r;
    endfunction

endpackage

// File: rtl/jtopl_multi_acc_lane.sv
// One mixer lane: frame accumulator, committed output,
// overflow/saturation handling and sticky clip flag.
module jtopl_acc_lane
    import jtopl_acc_pkg::*;
#(
    parameter int OUTW = 16,
    parameter int SAT  = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cenop,
    input  logic            zero,
    input  logic [OUTW-1:0] cur,
    input  logic [1:0]      shift,
    input  logic            clip_clr,
    output logic [OUTW-1:0] snd,
    output logic            clip
);

    localparam int EW = OUTW + 3;

    logic [OUTW-1:0]      acc;
    logic [OUTW-1:0]      acc_nxt;
    logic [OUTW-1:0]      shd;
    logic [OUTW-1:0]      vmax;
    logic [OUTW-1:0]      vmin;
    logic signed [EW-1:0] ext;
    logic [3:0]           top;
    logic                 ovf;
    logic                 sovf;
    logic                 clip_set;
    add_res_t             ar;

    always_comb begin
        vmax    = OUTW'(sat_max(OUTW));
        vmin    = OUTW'(sat_min(OUTW));
        ar      = add_ovf(32'($signed(acc)), 32'($signed(cur)), OUTW);
        ovf     = ar.ovf;
        acc_nxt = OUTW'(ar.sum);
        if (ovf && SAT != 0)
            acc_nxt = acc[OUTW-1] ? vmin : vmax;
        // Three guard bits catch anything shifted past the sign
        ext  = EW'($signed(acc)) <<< shift;
        top  = ext[EW-1:OUTW-1];
        sovf = !((&top) || !(|top));
        shd  = ext[OUTW-1:0];
        if (sovf)
            shd = acc[OUTW-1] ? vmin : vmax;
        clip_set = cenop && (zero ? sovf : ovf);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
            snd <= '0;
        end else if (cenop) begin
            if (zero) begin
                snd <= shd;
                acc <= cur;
            end else begin
                acc <= acc_nxt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            clip <= 1'b0;
        else if (clip_set)
            clip <= 1'b1;
        else if (clip_clr)
            clip <= 1'b0;
    end

endmodule

// File: rtl/jtopl_multi_acc.sv
// Multi-lane saturating mixer: routes each operator slot into
// selected lanes and commits gain-shifted frame sums on zero.
module jtopl_multi_acc
    import jtopl_acc_pkg::*;
#(
    parameter int INW  = 13,
    parameter int OUTW = 16,
    parameter int CH   = 2,
    parameter int SAT  = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cenop,
    input  logic [INW-1:0]     op_result,
    input  logic [CH-1:0]      sum_en,
    input  logic               zero,
    input  logic [1:0]         shift,
    input  logic               clip_clr,
    output logic [CH*OUTW-1:0] snd,
    output logic               snd_valid,
    output logic [CH-1:0]      clip
);

    logic [OUTW-1:0] sample;

    assign sample = OUTW'(sext(32'(op_result), INW));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            snd_valid <= 1'b0;
        else
            snd_valid <= cenop & zero;
    end

    for (genvar c = 0; c < CH; c++) begin : g_lane
        logic [OUTW-1:0] cur;

        assign cur = sum_en[c] ? sample : '0;

        jtopl_acc_lane #(
            .OUTW (OUTW),
            .SAT  (SAT)
        ) u_lane (
            .clk      (clk),
            .rst_n    (rst_n),
            .cenop    (cenop),
            .zero     (zero),
            .cur      (cur),
            .shift    (shift),
            .clip_clr (clip_clr),
            .snd      (snd[c*OUTW +: OUTW]),
            .clip     (clip[c])
        );
    end

endmodule

// File: tb/tb_jtopl_multi_acc.sv
// Directed bench for jtopl_multi_acc: saturating and
// wrapping builds driven in lockstep.
module tb_jtopl_multi_acc;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cenop;
    logic [12:0] op_result;
    logic [1:0]  sum_en;
    logic        zero;
    logic [1:0]  shift;
    logic        clip_clr;
    logic [31:0] snd;
    logic        snd_valid;
    logic [1:0]  clip;
    logic [31:0] snd_w;
    logic        snd_valid_w;
    logic [1:0]  clip_w;

    int total = 0;
    int bad   = 0;
    int vcount;

    always #5 clk = ~clk;

    jtopl_multi_acc #(
        .INW(13), .OUTW(16), .CH(2), .SAT(1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cenop     (cenop),
        .op_result (op_result),
        .sum_en    (sum_en),
        .zero      (zero),
        .shift     (shift),
        .clip_clr  (clip_clr),
        .snd       (snd),
        .snd_valid (snd_valid),
        .clip      (clip)
    );

    jtopl_multi_acc #(
        .INW(13), .OUTW(16), .CH(2), .SAT(0)
    ) dut_w (
        .clk       (clk),
        .rst_n     (rst_n),
        .cenop     (cenop),
        .op_result (op_result),
        .sum_en    (sum_en),
        .zero      (zero),
        .shift     (shift),
        .clip_clr  (clip_clr),
        .snd       (snd_w),
        .snd_valid (snd_valid_w),
        .clip      (clip_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic slot(input int v, input logic [1:0] en, input logic z);
        op_result = 13'(v);
        sum_en    = en;
        zero      = z;
        cenop     = 1'b1;
        @(posedge clk);
        #1;
        cenop = 1'b0;
        zero  = 1'b0;
    endtask

    task automatic idle(input logic clr);
        cenop    = 1'b0;
        clip_clr = clr;
        @(posedge clk);
        #1;
        clip_clr = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cenop     = 1'b0;
        op_result = '0;
        sum_en    = '0;
        zero      = 1'b0;
        shift     = 2'd0;
        clip_clr  = 1'b0;
        #1;
        chk("rst_snd", snd, 32'h0);
        chk("rst_vld", 32'(snd_valid), 32'h0);
        chk("rst_clip", 32'(clip), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // lane0 only frame
        slot(100, 2'b01, 1'b0);
        slot(200, 2'b01, 1'b0);
        slot(-50, 2'b01, 1'b0);
        slot(0, 2'b00, 1'b1);
        chk("t1_snd", snd, 32'h0000_00FA);
        chk("t1_vld", 32'(snd_valid), 32'h1);
        chk("t1_clip", 32'(clip), 32'h0);
        slot(0, 2'b00, 1'b0);
        chk("t1_vld_off", 32'(snd_valid), 32'h0);

        // positive and negative overflow
        for (int i = 0; i < 9; i++) slot(4095, 2'b11, 1'b0);
        slot(0, 2'b00, 1'b1);
        chk("t2_sat_pos", snd, 32'h7FFF_7FFF);
        chk("t2_clip", 32'(clip), 32'h3);
        chk("t2_wrap_pos", snd_w, 32'h8FF7_8FF7);
        chk("t2_clip_w", 32'(clip_w), 32'h3);
        for (int i = 0; i < 9; i++) slot(-4096, 2'b11, 1'b0);
        slot(0, 2'b00, 1'b1);
        chk("t2_sat_neg", snd, 32'h8000_8000);
        chk("t2_wrap_neg", snd_w, 32'h7000_7000);
        idle(1'b1);
        chk("t2_clr", 32'(clip), 32'h0);

        // output gain shift
        shift = 2'd2;
        slot(1000, 2'b01, 1'b0);
        slot(0, 2'b00, 1'b1);
        chk("t3_shift", snd, 32'h0000_0FA0);
        chk("t3_clip0", 32'(clip), 32'h0);
        for (int i = 0; i < 3; i++) slot(3000, 2'b01, 1'b0);
        for (int i = 0; i < 3; i++) slot(-3000, 2'b10, 1'b0);
        slot(0, 2'b00, 1'b1);
        chk("t3_shift_sat", snd, 32'h8000_7FFF);
        chk("t3_clip", 32'(clip), 32'h3);
        chk("t3_wrap_clamp", snd_w, 32'h8000_7FFF);
        shift = 2'd0;
        idle(1'b1);

        // zero slot sample starts the next frame
        slot(7, 2'b10, 1'b1);
        chk("t4_commit0", snd, 32'h0);
        for (int i = 0; i < 3; i++) slot(1, 2'b10, 1'b0);
        slot(0, 2'b00, 1'b1);
        chk("t4_carry", snd, 32'h000A_0000);
        chk("t4_clip", 32'(clip), 32'h0);

        // cenop low freezes everything
        slot(5, 2'b01, 1'b0);
        vcount = 0;
        for (int i = 0; i < 20; i++) begin
            cenop     = 1'b0;
            op_result = 13'(i * 37);
            zero      = i[0];
            sum_en    = 2'b11;
            @(posedge clk);
            #1;
            if (snd_valid) vcount++;
        end
        zero = 1'b0;
        chk("t5_no_vld", 32'(vcount), 32'h0);
        chk("t5_snd_hold", snd, 32'h000A_0000);
        slot(0, 2'b00, 1'b1);
        chk("t5_acc_hold", snd, 32'h0000_0005);

        // set wins over clear in the same cycle
        for (int i = 0; i < 8; i++) slot(4095, 2'b01, 1'b0);
        clip_clr = 1'b1;
        slot(4095, 2'b01, 1'b0);
        clip_clr = 1'b0;
        chk("t5_set_wins", 32'(clip), 32'h1);

        // async reset mid-frame
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_snd", snd, 32'h0);
        chk("t6_rst_clip", 32'(clip), 32'h0);
        chk("t6_rst_vld", 32'(snd_valid), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        slot(10, 2'b01, 1'b0);
        slot(20, 2'b01, 1'b0);
        slot(0, 2'b00, 1'b1);
        chk("t6_post_rst", snd, 32'h0000_001E);
        chk("t6_clip", 32'(clip), 32'h0);

        // shift clamp, back-to-back commits, clear alone
        shift = 2'd3;
        slot(4095, 2'b01, 1'b0);
        slot(4095, 2'b01, 1'b0);
        slot(0, 2'b00, 1'b1);
        chk("t7_shift3", snd, 32'h0000_7FFF);
        chk("t7_clip", 32'(clip), 32'h1);
        shift = 2'd0;
        slot(3, 2'b01, 1'b1);
        chk("t7_z1_snd", snd, 32'h0);
        chk("t7_z1_vld", 32'(snd_valid), 32'h1);
        slot(4, 2'b01, 1'b1);
        chk("t7_z2_snd", snd, 32'h0000_0003);
        chk("t7_z2_vld", 32'(snd_valid), 32'h1);
        idle(1'b1);
        chk("t7_clr", 32'(clip), 32'h0);
        chk("t7_vld_off", 32'(snd_valid), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
